// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 definitions for the write arbiter and its round-robin picker.
// Contents:
//   arb_state_t  - arbiter FSM encoding (IDLE=0, ADDR=1, DATA=2, RESP=3)
//   BURST_*      - AWBURST type codes
//   RESP_*       - BRESP codes
//   PTR_W        - width of the round-robin pointer (enough for up to 4 masters)
//   rr_next()    - advance a master index cyclically
// -----------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PTR_W = 2;

  // Index of the master after idx, wrapping at nm.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int nm);
    rr_next = (idx == PTR_W'(nm - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker: returns the first asserted
// request at or after ptr, searching cyclically, as a one-hot vector.
// Ports:
//   req  in  NM     request vector
//   ptr  in  PTR_W  index with highest priority this round
//   gnt  out NM     one-hot winner, 0 when no request is set
// -----------------------------------------------------------------------------
module rr_pick
  import axi_pkg::*;
#(
  parameter int NM = 2
) (
  input  logic [NM-1:0]    req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NM-1:0]    gnt
);

  logic found;

  // Walk the masters starting from ptr; the first requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && req[(int'(ptr) + i) % NM]) begin
        gnt[(int'(ptr) + i) % NM] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi_write_arbiter
// Shares one AXI3 write slave port between NM upstream write masters, one
// transaction at a time, with round-robin fairness. The grant is held from
// address acceptance through the write response. WLAST downstream comes from
// an internal beat counter; upstream WLAST disagreeing with it raises wlast_err.
// Ports:
//   ACLK, ARESET             clock, async active-high reset
//   S_AW*/S_W*/S_B*          upstream channels, master k at slice [k*w +: w]
//   M_AW*/M_W*/M_B*          downstream channels to the interconnect/slave
//   grant                    one-hot current owner, 0 when idle
//   wlast_err                one-cycle pulse after a W beat with a WLAST mismatch
// -----------------------------------------------------------------------------
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int NM = 2,
  parameter int DW = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [NM*4-1:0]      S_AWID,
  input  logic [NM*32-1:0]     S_AWADDR,
  input  logic [NM*4-1:0]      S_AWLEN,
  input  logic [NM*3-1:0]      S_AWSIZE,
  input  logic [NM*2-1:0]      S_AWBURST,
  input  logic [NM-1:0]        S_AWVALID,
  output logic [NM-1:0]        S_AWREADY,
  input  logic [NM*4-1:0]      S_WID,
  input  logic [NM*DW-1:0]     S_WDATA,
  input  logic [NM*DW/8-1:0]   S_WSTRB,
  input  logic [NM-1:0]        S_WLAST,
  input  logic [NM-1:0]        S_WVALID,
  output logic [NM-1:0]        S_WREADY,
  output logic [NM*4-1:0]      S_BID,
  output logic [NM*2-1:0]      S_BRESP,
  output logic [NM-1:0]        S_BVALID,
  input  logic [NM-1:0]        S_BREADY,
  output logic [3:0]           M_AWID,
  output logic [31:0]          M_AWADDR,
  output logic [3:0]           M_AWLEN,
  output logic [2:0]           M_AWSIZE,
  output logic [1:0]           M_AWBURST,
  output logic                 M_AWVALID,
  input  logic                 M_AWREADY,
  output logic [3:0]           M_WID,
  output logic [DW-1:0]        M_WDATA,
  output logic [DW/8-1:0]      M_WSTRB,
  output logic                 M_WLAST,
  output logic                 M_WVALID,
  input  logic                 M_WREADY,
  input  logic [3:0]           M_BID,
  input  logic [1:0]           M_BRESP,
  input  logic                 M_BVALID,
  output logic                 M_BREADY,
  output logic [NM-1:0]        grant,
  output logic                 wlast_err
);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  logic [3:0]       beat;
  logic [3:0]       len_q;
  logic [3:0]       pick_len;
  logic [NM-1:0]    pick;
  logic             last_beat;
  logic             sel_wlast;

  rr_pick #(.NM(NM)) u_pick (
    .req (S_AWVALID),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Index of the granted master and the AWLEN of the master about to be picked.
  always_comb begin
    gidx     = '0;
    pick_len = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) gidx = PTR_W'(k);
      if (pick[k])  pick_len = S_AWLEN[k*4 +: 4];
    end
  end

  assign last_beat = (beat == len_q);
  assign sel_wlast = |(grant & S_WLAST);

  // Downstream muxes are AND-OR on the registered grant, so everything reads
  // zero while idle and nothing depends combinationally on S_AWVALID.
  always_comb begin
    M_AWID    = '0;
    M_AWADDR  = '0;
    M_AWLEN   = '0;
    M_AWSIZE  = '0;
    M_AWBURST = '0;
    M_WID     = '0;
    M_WDATA   = '0;
    M_WSTRB   = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) begin
        M_AWID    = S_AWID[k*4 +: 4];
        M_AWADDR  = S_AWADDR[k*32 +: 32];
        M_AWLEN   = S_AWLEN[k*4 +: 4];
        M_AWSIZE  = S_AWSIZE[k*3 +: 3];
        M_AWBURST = S_AWBURST[k*2 +: 2];
        M_WID     = S_WID[k*4 +: 4];
        M_WDATA   = S_WDATA[k*DW +: DW];
        M_WSTRB   = S_WSTRB[k*(DW/8) +: (DW/8)];
      end
    end
  end

  assign M_AWVALID = (state == ADDR);
  assign M_WVALID  = (state == DATA) && |(grant & S_WVALID);
  assign M_WLAST   = (state == DATA) && last_beat;
  assign M_BREADY  = (state == RESP) && |(grant & S_BREADY);

  // Upstream handshakes and responses reach only the granted master.
  always_comb begin
    S_AWREADY = '0;
    S_WREADY  = '0;
    S_BVALID  = '0;
    S_BID     = '0;
    S_BRESP   = '0;
    for (int k = 0; k < NM; k++) begin
      S_AWREADY[k] = grant[k] && (state == ADDR) && M_AWREADY;
      S_WREADY[k]  = grant[k] && (state == DATA) && M_WREADY;
      S_BVALID[k]  = grant[k] && (state == RESP) && M_BVALID;
      if (grant[k] && (state == RESP)) begin
        S_BID[k*4 +: 4]   = M_BID;
        S_BRESP[k*2 +: 2] = M_BRESP;
      end
    end
  end

  // Transaction FSM: grant on request, forward AW, count W beats up to len_q,
  // then hand the response back and move the round-robin pointer past the owner.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat      <= '0;
      len_q     <= '0;
      wlast_err <= 1'b0;
    end else begin
      wlast_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|S_AWVALID) begin
            grant <= pick;
            len_q <= pick_len;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (M_AWREADY) begin
            beat  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (M_WVALID && M_WREADY) begin
            // The counter wraps here for AWLEN=15, but only as DATA is left.
            beat      <= beat + 4'd1;
            wlast_err <= (sel_wlast != last_beat);
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          if (M_BVALID && M_BREADY) begin
            rr_ptr <= rr_next(gidx, NM);
            grant  <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_write_arbiter
// Self-checking bench for axi_write_arbiter (NM=2, DW=32). Upstream masters are
// driven by applyStimulus, which also pushes the expected AW record and W data
// into per-master scoreboard queues; the expected grant order is queued by the
// test sequence. A negedge monitor pops and compares on each downstream
// handshake, and a small slave model answers with B responses.
// -----------------------------------------------------------------------------
module tb_axi_write_arbiter;
  import axi_pkg::*;

  localparam int NM = 2;
  localparam int DW = 32;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_t;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [NM*4-1:0]    S_AWID, S_WID, S_BID, S_AWLEN;
  logic [NM*32-1:0]   S_AWADDR;
  logic [NM*3-1:0]    S_AWSIZE;
  logic [NM*2-1:0]    S_AWBURST, S_BRESP;
  logic [NM-1:0]      S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
  logic [NM-1:0]      S_BVALID, S_BREADY;
  logic [NM*DW-1:0]   S_WDATA;
  logic [NM*DW/8-1:0] S_WSTRB;
  logic [3:0]         M_AWID, M_AWLEN, M_WID, M_BID;
  logic [31:0]        M_AWADDR;
  logic [2:0]         M_AWSIZE;
  logic [1:0]         M_AWBURST, M_BRESP;
  logic               M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY;
  logic               M_BVALID, M_BREADY, wlast_err;
  logic [DW-1:0]      M_WDATA;
  logic [DW/8-1:0]    M_WSTRB;
  logic [NM-1:0]      grant;

  axi_write_arbiter #(.NM(NM), .DW(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WID(M_WID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .grant(grant), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail = 0;
  int beats_total = 0;
  int err_pulses = 0;
  int stable_checks = 0;
  int cyc = 0;

  int          gnt_q[$];
  aw_t         aw_q0[$], aw_q1[$];
  logic [DW-1:0] wd_q0[$], wd_q1[$];

  bit          bp_mode = 0;
  bit          chk_early = 0;
  bit          chk_gap = 0;
  logic [1:0]  b_resp_val = RESP_OKAY;
  bit          b_pend = 0, b_ack = 0;
  logic [3:0]  b_id = '0;
  int          aw_wait_cnt = 0;

  int          cur_m = 0;
  aw_t         cur_aw;
  int          beat_idx = 0;
  bit          prev_wait = 0;
  logic [39:0] prev_aw = '0;
  bit          have_b = 0;
  int          b_cyc = 0;
  logic [NM-1:0] prev_grant = '0;

  // Single comparison point: counts every check, reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic zeroInputs();
    S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = '0;
    S_WID = '0; S_WDATA = '0; S_WSTRB = '0; S_WLAST = '0; S_WVALID = '0; S_BREADY = '0;
  endtask

  task automatic flushScoreboard();
    gnt_q.delete(); aw_q0.delete(); aw_q1.delete(); wd_q0.delete(); wd_q1.delete();
  endtask

  task automatic pulseReset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    zeroInputs();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    flushScoreboard();
  endtask

  // One complete write transaction from master m; bad_beat >= 0 also raises
  // WLAST on that beat index.
  task automatic applyStimulus(input int m, input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [DW-1:0] base, input int bad_beat);
    aw_t rec;
    bit ok;
    logic [NM-1:0] others;
    rec = '{id: id, addr: addr, len: len, size: 3'b010, burst: BURST_INCR};
    if (m == 0) aw_q0.push_back(rec); else aw_q1.push_back(rec);
    for (int b = 0; b <= int'(len); b++) begin
      if (m == 0) wd_q0.push_back(base + DW'(b)); else wd_q1.push_back(base + DW'(b));
    end
    S_AWID[m*4 +: 4] = id; S_AWADDR[m*32 +: 32] = addr; S_AWLEN[m*4 +: 4] = len;
    S_AWSIZE[m*3 +: 3] = 3'b010; S_AWBURST[m*2 +: 2] = BURST_INCR; S_AWVALID[m] = 1'b1;
    if (chk_early) begin
      #1 checkOutput("no_comb_aw", {grant, M_AWVALID}, '0);
    end
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge ACLK);
      if (S_AWREADY[m]) begin ok = 1; break; end
    end
    checkOutput("aw_accepted", ok, 1);
    @(posedge ACLK); #1;
    S_AWVALID[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      S_WID[m*4 +: 4] = id; S_WDATA[m*DW +: DW] = base + DW'(b);
      S_WSTRB[m*(DW/8) +: (DW/8)] = '1;
      S_WLAST[m] = (b == int'(len)) || (b == bad_beat);
      S_WVALID[m] = 1'b1;
      ok = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge ACLK);
        if (S_WREADY[m]) begin ok = 1; break; end
      end
      if (!ok) checkOutput("w_accepted", ok, 1);
      @(posedge ACLK); #1;
    end
    S_WVALID[m] = 1'b0; S_WLAST[m] = 1'b0;
    S_BREADY[m] = 1'b1;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge ACLK);
      if (S_BVALID[m]) begin ok = 1; break; end
    end
    checkOutput("b_seen", ok, 1);
    if (ok) begin
      others = S_BVALID;
      others[m] = 1'b0;
      checkOutput("bresp", S_BRESP[m*2 +: 2], b_resp_val);
      checkOutput("bid", S_BID[m*4 +: 4], id);
      checkOutput("bvalid_other", others, '0);
    end
    @(posedge ACLK); #1;
    S_BREADY[m] = 1'b0;
  endtask

  always @(posedge ACLK) cyc++;

  // Slave model: ready patterns and B responses after the last beat.
  always @(posedge ACLK) begin
    #1;
    if (ARESET) begin
      M_BVALID = 1'b0; b_ack = 0; b_pend = 0;
    end else begin
      if (b_ack) begin M_BVALID = 1'b0; b_ack = 0; end
      if (b_pend) begin M_BVALID = 1'b1; M_BID = b_id; M_BRESP = b_resp_val; b_pend = 0; end
    end
    if (M_AWVALID) aw_wait_cnt++; else aw_wait_cnt = 0;
    M_AWREADY = !bp_mode || (aw_wait_cnt > 5);
    M_WREADY  = bp_mode ? ~M_WREADY : 1'b1;
  end

  // Monitor: compares downstream handshakes against the scoreboard.
  always @(negedge ACLK) begin
    logic [DW-1:0] exp_d;
    bit have;
    if (ARESET) begin
      beat_idx = 0; prev_wait = 0; have_b = 0; prev_grant = '0;
    end else begin
      if (wlast_err) err_pulses++;
      if (chk_gap && grant != '0 && prev_grant == '0 && have_b)
        checkOutput("b2b_gap", cyc - b_cyc, 2);
      prev_grant = grant;
      if (prev_wait && M_AWVALID) begin
        stable_checks++;
        checkOutput("aw_stable", {M_AWID, M_AWADDR, M_AWLEN}, prev_aw);
      end
      prev_wait = M_AWVALID && !M_AWREADY;
      prev_aw   = {M_AWID, M_AWADDR, M_AWLEN};
      if (M_AWVALID && M_AWREADY) begin
        have = (gnt_q.size() != 0);
        checkOutput("gnt_expected", have, 1);
        if (have) begin
          cur_m = gnt_q.pop_front();
          checkOutput("grant", grant, 64'(1) << cur_m);
          have = (cur_m == 0) ? (aw_q0.size() != 0) : (aw_q1.size() != 0);
          checkOutput("aw_expected", have, 1);
          if (have) begin
            cur_aw = (cur_m == 0) ? aw_q0.pop_front() : aw_q1.pop_front();
            checkOutput("aw_payload", {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST}, cur_aw);
          end
          beat_idx = 0;
        end
      end
      if (M_WVALID && M_WREADY) begin
        have = (cur_m == 0) ? (wd_q0.size() != 0) : (wd_q1.size() != 0);
        checkOutput("w_expected", have, 1);
        if (have) begin
          exp_d = (cur_m == 0) ? wd_q0.pop_front() : wd_q1.pop_front();
          checkOutput("wbeat", {M_WID, M_WSTRB, M_WDATA}, {cur_aw.id, {(DW/8){1'b1}}, exp_d});
        end
        checkOutput("wlast", M_WLAST, beat_idx == int'(cur_aw.len));
        if (beat_idx == int'(cur_aw.len)) begin b_pend = 1; b_id = cur_aw.id; end
        beat_idx++;
        beats_total++;
      end
      if (M_BVALID && M_BREADY) begin
        b_ack = 1; have_b = 1; b_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0, e0, s0;
    bit ok;
    M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b0; M_BID = '0; M_BRESP = '0;
    zeroInputs();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    $display("[TB] reset state");
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_awvalid", M_AWVALID, 0);
    checkOutput("rst_wvalid", M_WVALID, 0);
    checkOutput("rst_wlast", M_WLAST, 0);
    checkOutput("rst_bready", M_BREADY, 0);
    checkOutput("rst_s_ready", {S_AWREADY, S_WREADY, S_BVALID}, 0);
    checkOutput("rst_wlast_err", wlast_err, 0);
    checkOutput("rst_payload", {M_AWADDR, M_WDATA}, 0);
    @(posedge ACLK); #1 ARESET = 1'b0;

    $display("[TB] single master 0, AWLEN=3");
    b0 = beats_total; e0 = err_pulses;
    chk_early = 1;
    gnt_q.push_back(0);
    applyStimulus(0, 4'h1, 32'h0000_1000, 4'd3, 32'hA0, -1);
    chk_early = 0;
    checkOutput("t1_beats", beats_total - b0, 4);
    checkOutput("t1_err", err_pulses - e0, 0);
    @(negedge ACLK);
    checkOutput("t1_grant_idle", grant, 0);

    $display("[TB] simultaneous requests, alternating grants");
    pulseReset();
    b0 = beats_total;
    chk_gap = 1;
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    fork
      begin
        applyStimulus(0, 4'h2, 32'h0000_2000, 4'd1, 32'h200, -1);
        applyStimulus(0, 4'h3, 32'h0000_2100, 4'd2, 32'h210, -1);
      end
      begin
        applyStimulus(1, 4'h4, 32'h0000_3000, 4'd2, 32'h300, -1);
        applyStimulus(1, 4'h5, 32'h0000_3100, 4'd1, 32'h310, -1);
      end
    join
    chk_gap = 0;
    checkOutput("t2_beats", beats_total - b0, 10);

    $display("[TB] early WLAST from master 1");
    b0 = beats_total; e0 = err_pulses;
    b_resp_val = RESP_SLVERR;
    gnt_q.push_back(1);
    applyStimulus(1, 4'h7, 32'h0000_4000, 4'd3, 32'h400, 1);
    b_resp_val = RESP_OKAY;
    checkOutput("t3_beats", beats_total - b0, 4);
    checkOutput("t3_err_pulses", err_pulses - e0, 1);

    $display("[TB] slave backpressure");
    b0 = beats_total; s0 = stable_checks;
    bp_mode = 1;
    gnt_q.push_back(0);
    applyStimulus(0, 4'h8, 32'h0000_5000, 4'd3, 32'h500, -1);
    bp_mode = 0;
    checkOutput("t4_beats", beats_total - b0, 4);
    checkOutput("t4_aw_waited", (stable_checks - s0) >= 4, 1);

    $display("[TB] reset during DATA beat 2");
    gnt_q.push_back(0);
    aw_q0.push_back('{id: 4'h6, addr: 32'h0000_6000, len: 4'd3, size: 3'b010, burst: BURST_INCR});
    for (int b = 0; b < 4; b++) wd_q0.push_back(32'h600 + DW'(b));
    S_AWID[3:0] = 4'h6; S_AWADDR[31:0] = 32'h0000_6000; S_AWLEN[3:0] = 4'd3;
    S_AWSIZE[2:0] = 3'b010; S_AWBURST[1:0] = BURST_INCR; S_AWVALID[0] = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      if (S_AWREADY[0]) begin ok = 1; break; end
    end
    checkOutput("t5_aw_accepted", ok, 1);
    @(posedge ACLK); #1;
    S_AWVALID[0] = 1'b0;
    S_WID[3:0] = 4'h6; S_WDATA[DW-1:0] = 32'h600; S_WSTRB[3:0] = 4'hF; S_WVALID[0] = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      if (S_WREADY[0]) begin ok = 1; break; end
    end
    checkOutput("t5_beat1", ok, 1);
    @(posedge ACLK); #1;
    S_WDATA[DW-1:0] = 32'h601;
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    checkOutput("t5_grant", grant, 0);
    checkOutput("t5_valids", {M_AWVALID, M_WVALID, M_WLAST, M_BREADY, wlast_err}, 0);
    checkOutput("t5_s_ready", {S_AWREADY, S_WREADY, S_BVALID}, 0);
    checkOutput("t5_payload", {M_WDATA, M_AWADDR}, 0);
    zeroInputs();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    flushScoreboard();

    $display("[TB] master 1 after reset");
    b0 = beats_total;
    gnt_q.push_back(1);
    applyStimulus(1, 4'h9, 32'h0000_7000, 4'd2, 32'h700, -1);
    checkOutput("t6_beats", beats_total - b0, 3);

    $display("[TB] AWLEN=15 burst");
    b0 = beats_total; e0 = err_pulses;
    gnt_q.push_back(0);
    applyStimulus(0, 4'hA, 32'h0000_8000, 4'd15, 32'h800, -1);
    checkOutput("t7_beats", beats_total - b0, 16);
    checkOutput("t7_err", err_pulses - e0, 0);
    @(negedge ACLK);
    checkOutput("t7_grant_idle", grant, 0);

    checkOutput("sb_drained", gnt_q.size() + aw_q0.size() + aw_q1.size() + wd_q0.size() + wd_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
